// File: rtl/vend_pkg.sv
// Shared encodings for the vending controller: coin codes, coin values,
// timer modes and controller states.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_20   = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT     = 2'b01,
    ST_DISPENSE = 2'b10,
    ST_CHANGE   = 2'b11
  } state_e;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_WAIT = 2'b01;
  localparam logic [1:0] MODE_PROD = 2'b10;
  localparam logic [1:0] MODE_CHG  = 2'b11;

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    logic [7:0] val;
    case (code)
      COIN_5:  val = 8'd5;
      COIN_10: val = 8'd10;
      COIN_20: val = 8'd20;
      default: val = 8'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_ctrl_timer.sv
// Mode-driven hold timer: re-arms whenever the mode changes and raises
// timeout_flag once the mode's tick budget has elapsed.
module vend_ctrl_timer
  import vend_pkg::*;
#(
  parameter int unsigned T_WAIT = 30,
  parameter int unsigned T_PROD = 5,
  parameter int unsigned T_CHG  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  output logic       timeout_flag
);

  logic [1:0]  mode_r;
  logic [15:0] cnt_r;
  logic [15:0] limit_s;

  // Tick budget for the requested mode.
  always_comb begin
    limit_s = 16'd0;
    case (mode)
      MODE_WAIT: limit_s = 16'(T_WAIT);
      MODE_PROD: limit_s = 16'(T_PROD);
      MODE_CHG:  limit_s = 16'(T_CHG);
      default:   limit_s = 16'd0;
    endcase
  end

  // Countdown; the flag stays high once the budget is used up until the next mode change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r       <= MODE_IDLE;
      cnt_r        <= 16'd0;
      timeout_flag <= 1'b0;
    end else if (mode != mode_r) begin
      mode_r       <= mode;
      cnt_r        <= limit_s;
      timeout_flag <= 1'b0;
    end else if (mode == MODE_IDLE) begin
      timeout_flag <= 1'b0;
    end else begin
      if (cnt_r != 16'd0) begin
        cnt_r <= cnt_r - 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      timeout_flag <= (cnt_r <= 16'd1);
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: credit accumulation, item selection, dispense
// and change payout, sequenced by a single mode-driven timer.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned T_WAIT     = 30,
  parameter int unsigned T_PROD     = 5,
  parameter int unsigned T_CHG      = 5,
  parameter int unsigned PRICE0     = 15,
  parameter int unsigned PRICE1     = 20,
  parameter int unsigned PRICE2     = 25,
  parameter int unsigned PRICE3     = 40,
  parameter int unsigned MAX_CREDIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] coin,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  output logic [7:0] credit,
  output logic       coin_reject,
  output logic       sel_reject,
  output logic       dispense,
  output logic [1:0] dispense_id,
  output logic       change_valid,
  output logic [7:0] change_amt,
  output logic       busy
);

  state_e     state, state_n;
  logic       first_r;
  logic       timeout_flag_s;
  logic       timeout_hit_s;
  logic [1:0] mode_s;
  logic       coin_present_s;
  logic [7:0] coin_val_s;
  logic [8:0] coin_sum_s;
  logic [7:0] price_s;

  logic [7:0] credit_n, change_amt_n;
  logic [1:0] dispense_id_n;
  logic       coin_reject_n, sel_reject_n, dispense_n, change_valid_n, busy_n;

  function automatic logic [7:0] item_price(input logic [1:0] id);
    logic [7:0] p;
    case (id)
      2'd0:    p = 8'(PRICE0);
      2'd1:    p = 8'(PRICE1);
      2'd2:    p = 8'(PRICE2);
      2'd3:    p = 8'(PRICE3);
      default: p = 8'(PRICE3);
    endcase
    return p;
  endfunction

  assign coin_present_s = (coin != COIN_NONE);
  assign coin_val_s     = coin_value(coin);
  assign coin_sum_s     = {1'b0, credit} + {1'b0, coin_val_s};
  assign price_s        = item_price(sel_id);
  // A flag seen in the first cycle of a state belongs to the previous mode.
  assign timeout_hit_s  = timeout_flag_s && !first_r;

  // Timer mode follows the state directly.
  always_comb begin
    mode_s = MODE_IDLE;
    case (state)
      ST_WAIT:     mode_s = MODE_WAIT;
      ST_DISPENSE: mode_s = MODE_PROD;
      ST_CHANGE:   mode_s = MODE_CHG;
      default:     mode_s = MODE_IDLE;
    endcase
  end

  vend_ctrl_timer #(
    .T_WAIT (T_WAIT),
    .T_PROD (T_PROD),
    .T_CHG  (T_CHG)
  ) timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode_s),
    .timeout_flag (timeout_flag_s)
  );

  // State register plus the first-cycle marker used for the stale-flag mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      first_r <= 1'b0;
    end else begin
      state   <= state_n;
      first_r <= (state_n != state);
    end
  end

  // Next-state logic; WAIT priority is cancel, then selection, then timeout.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (coin_present_s) state_n = ST_WAIT;
        else                state_n = ST_IDLE;
      end
      ST_WAIT: begin
        if (cancel)                              state_n = ST_CHANGE;
        else if (sel_valid && credit >= price_s) state_n = ST_DISPENSE;
        else if (timeout_hit_s)                  state_n = ST_CHANGE;
        else                                     state_n = ST_WAIT;
      end
      ST_DISPENSE: begin
        if (timeout_hit_s) state_n = ST_CHANGE;
        else               state_n = ST_DISPENSE;
      end
      ST_CHANGE: begin
        if (timeout_hit_s) state_n = ST_IDLE;
        else               state_n = ST_CHANGE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    credit_n       = credit;
    coin_reject_n  = 1'b0;
    sel_reject_n   = 1'b0;
    dispense_n     = 1'b0;
    dispense_id_n  = dispense_id;
    change_valid_n = 1'b0;
    change_amt_n   = change_amt;
    busy_n         = (state_n == ST_DISPENSE) || (state_n == ST_CHANGE);
    case (state)
      ST_IDLE: begin
        if (coin_present_s) credit_n = coin_sum_s[7:0];
        else                credit_n = credit;
      end
      ST_WAIT: begin
        if (cancel || sel_valid || timeout_hit_s) begin
          coin_reject_n = coin_present_s;
        end else if (coin_present_s) begin
          if (coin_sum_s <= 9'(MAX_CREDIT)) credit_n = coin_sum_s[7:0];
          else                              coin_reject_n = 1'b1;
        end else begin
          credit_n = credit;
        end
        if (!cancel && sel_valid) begin
          if (state_n == ST_DISPENSE) begin
            credit_n      = credit - price_s;
            dispense_n    = 1'b1;
            dispense_id_n = sel_id;
          end else begin
            sel_reject_n = 1'b1;
          end
        end else begin
          sel_reject_n = 1'b0;
        end
      end
      ST_DISPENSE, ST_CHANGE: coin_reject_n = coin_present_s;
      default:                coin_reject_n = 1'b0;
    endcase
    // Change is paid out on every entry to CHANGE, even when it is zero.
    if (state_n == ST_CHANGE && state != ST_CHANGE) begin
      change_valid_n = 1'b1;
      change_amt_n   = credit;
      credit_n       = 8'd0;
    end else begin
      change_valid_n = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit       <= 8'd0;
      coin_reject  <= 1'b0;
      sel_reject   <= 1'b0;
      dispense     <= 1'b0;
      dispense_id  <= 2'd0;
      change_valid <= 1'b0;
      change_amt   <= 8'd0;
      busy         <= 1'b0;
    end else begin
      credit       <= credit_n;
      coin_reject  <= coin_reject_n;
      sel_reject   <= sel_reject_n;
      dispense     <= dispense_n;
      dispense_id  <= dispense_id_n;
      change_valid <= change_valid_n;
      change_amt   <= change_amt_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with T_WAIT=8, T_PROD=2, T_CHG=2; each timed
// state lasts T+2 cycles from entry to exit.
module tb_vend_ctrl;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'b00;
  logic       cancel = 1'b0;
  logic [7:0] credit;
  logic       coin_reject;
  logic       sel_reject;
  logic       dispense;
  logic [1:0] dispense_id;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cv_seen  = 0;

  vend_ctrl #(.T_WAIT(8), .T_PROD(2), .T_CHG(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin         (coin),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .sel_reject   (sel_reject),
    .dispense     (dispense),
    .dispense_id  (dispense_id),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] c, input logic sv, input logic [1:0] sid, input logic cn);
    coin = c; sel_valid = sv; sel_id = sid; cancel = cn;
    @(posedge clk);
    #1;
    coin = 2'b00; sel_valid = 1'b0; sel_id = 2'b00; cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(COIN_NONE, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic check_state(input string tag, input state_e exp);
    check(tag, 32'(dut.state), 32'(exp));
  endtask

  initial begin
    // Reset values
    #12;
    check_state("rst_state", ST_IDLE);
    check("rst_credit", 32'(credit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_change_amt", 32'(change_amt), 32'd0);
    rst_n = 1'b1;

    // IDLE ignores selection and cancel
    cyc(COIN_NONE, 1'b1, 2'd3, 1'b1);
    check_state("idle_ignore_state", ST_IDLE);
    check("idle_ignore_selrej", 32'(sel_reject), 32'd0);

    // Scenario 1: 10 + 20, buy item 1 (price 20), change 10
    cyc(COIN_10, 1'b0, 2'd0, 1'b0);
    check("s1_credit10", 32'(credit), 32'd10);
    check_state("s1_wait", ST_WAIT);
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    check("s1_credit30", 32'(credit), 32'd30);
    cyc(COIN_NONE, 1'b1, 2'd1, 1'b0);
    check("s1_dispense", 32'(dispense), 32'd1);
    check("s1_dispense_id", 32'(dispense_id), 32'd1);
    check("s1_credit_after", 32'(credit), 32'd10);
    check("s1_busy", 32'(busy), 32'd1);
    check_state("s1_disp_state", ST_DISPENSE);
    idle(3);
    check_state("s1_disp_hold", ST_DISPENSE);
    check("s1_dispense_done", 32'(dispense), 32'd0);
    idle(1);
    check_state("s1_change_state", ST_CHANGE);
    check("s1_change_valid", 32'(change_valid), 32'd1);
    check("s1_change_amt", 32'(change_amt), 32'd10);
    check("s1_credit_clr", 32'(credit), 32'd0);
    check("s1_id_held", 32'(dispense_id), 32'd1);
    idle(3);
    check_state("s1_change_hold", ST_CHANGE);
    check("s1_change_pulse_end", 32'(change_valid), 32'd0);
    idle(1);
    check_state("s1_idle", ST_IDLE);
    check("s1_busy_low", 32'(busy), 32'd0);
    check("s1_amt_held", 32'(change_amt), 32'd10);

    // Scenario 2: 5 then unaffordable item 3, WAIT timeout pays 5
    cyc(COIN_5, 1'b0, 2'd0, 1'b0);
    cyc(COIN_NONE, 1'b1, 2'd3, 1'b0);
    check("s2_sel_reject", 32'(sel_reject), 32'd1);
    check("s2_credit", 32'(credit), 32'd5);
    check_state("s2_stay_wait", ST_WAIT);
    idle(8);
    check_state("s2_wait_before_to", ST_WAIT);
    check("s2_selrej_end", 32'(sel_reject), 32'd0);
    idle(1);
    check_state("s2_timeout_change", ST_CHANGE);
    check("s2_change_valid", 32'(change_valid), 32'd1);
    check("s2_change_amt", 32'(change_amt), 32'd5);
    idle(4);
    check_state("s2_idle", ST_IDLE);

    // Scenario 3: credit 90, coin 20 refused, cancel pays 90
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    cyc(COIN_10, 1'b0, 2'd0, 1'b0);
    check("s3_credit90", 32'(credit), 32'd90);
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    check("s3_coin_reject", 32'(coin_reject), 32'd1);
    check("s3_credit_kept", 32'(credit), 32'd90);
    cyc(COIN_NONE, 1'b0, 2'd0, 1'b1);
    check_state("s3_cancel_change", ST_CHANGE);
    check("s3_change_valid", 32'(change_valid), 32'd1);
    check("s3_change_amt", 32'(change_amt), 32'd90);
    check("s3_coinrej_end", 32'(coin_reject), 32'd0);
    idle(4);

    // Ceiling boundary: exactly 100 accepted, 105 refused
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    check("max_credit100", 32'(credit), 32'd100);
    check("max_no_reject", 32'(coin_reject), 32'd0);
    cyc(COIN_5, 1'b0, 2'd0, 1'b0);
    check("max_reject105", 32'(coin_reject), 32'd1);
    check("max_credit_kept", 32'(credit), 32'd100);
    cyc(COIN_NONE, 1'b0, 2'd0, 1'b1);
    check("max_change_amt", 32'(change_amt), 32'd100);
    idle(4);

    // Scenario 4: cancel + selection + coin in the same WAIT cycle
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    cyc(COIN_10, 1'b1, 2'd0, 1'b1);
    check_state("s4_change", ST_CHANGE);
    check("s4_coin_reject", 32'(coin_reject), 32'd1);
    check("s4_no_dispense", 32'(dispense), 32'd0);
    check("s4_change_amt", 32'(change_amt), 32'd20);
    check("s4_id_unchanged", 32'(dispense_id), 32'd1);
    idle(4);
    check_state("s4_idle", ST_IDLE);

    // Scenario 5: exact price, zero change, coin refused in DISPENSE, fresh WAIT timeout
    cyc(COIN_10, 1'b0, 2'd0, 1'b0);
    cyc(COIN_5, 1'b0, 2'd0, 1'b0);
    cyc(COIN_NONE, 1'b1, 2'd0, 1'b0);
    check("s5_dispense", 32'(dispense), 32'd1);
    check("s5_dispense_id", 32'(dispense_id), 32'd0);
    check("s5_credit0", 32'(credit), 32'd0);
    cyc(COIN_5, 1'b0, 2'd0, 1'b0);
    check("s5_disp_coin_reject", 32'(coin_reject), 32'd1);
    check_state("s5_disp_state", ST_DISPENSE);
    idle(2);
    check_state("s5_disp_hold", ST_DISPENSE);
    idle(1);
    check("s5_change_valid", 32'(change_valid), 32'd1);
    check("s5_change_zero", 32'(change_amt), 32'd0);
    idle(4);
    check_state("s5_idle", ST_IDLE);
    cyc(COIN_5, 1'b0, 2'd0, 1'b0);
    check_state("s5_rearm_wait", ST_WAIT);
    idle(9);
    check_state("s5_wait_hold", ST_WAIT);
    idle(1);
    check_state("s5_wait_timeout", ST_CHANGE);
    check("s5_timeout_amt", 32'(change_amt), 32'd5);
    idle(4);

    // Scenario 6: reset during DISPENSE
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    cyc(COIN_20, 1'b0, 2'd0, 1'b0);
    cyc(COIN_NONE, 1'b1, 2'd1, 1'b0);
    check_state("s6_in_dispense", ST_DISPENSE);
    check("s6_credit20", 32'(credit), 32'd20);
    #2 rst_n = 1'b0;
    #1;
    check_state("s6_rst_state", ST_IDLE);
    check("s6_rst_credit", 32'(credit), 32'd0);
    check("s6_rst_dispense", 32'(dispense), 32'd0);
    check("s6_rst_id", 32'(dispense_id), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_change_amt", 32'(change_amt), 32'd5 - 32'd5);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (change_valid) cv_seen++;
    end
    check("s6_no_change_pulse", 32'(cv_seen), 32'd0);
    check_state("s6_idle_after", ST_IDLE);
    cyc(COIN_5, 1'b0, 2'd0, 1'b0);
    check_state("s6_wait", ST_WAIT);
    check("s6_credit5", 32'(credit), 32'd5);
    idle(9);
    check_state("s6_wait_hold", ST_WAIT);
    idle(1);
    check_state("s6_timeout", ST_CHANGE);
    check("s6_change_amt", 32'(change_amt), 32'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
